gon_axi2apb_wr_bridge: RTL and testbench
========================================

Name: gon_axi2apb_wr_bridge

Overview:
Write-path half of the AXI-to-APB bridge. Accepts one AXI write burst at a time from the AXI master side (AW, W and B channels) and converts each data beat into one APB write transfer. It returns a single B response per burst. Sits directly downstream of the AXI master interface; the read-path half and the APB mux are separate blocks.

Parameters:
C_AXI_ID_WIDTH, 1, AWID/BID width
C_AXI_ADDR_WIDTH, 32, AXI and APB address width
C_AXI_DATA_WIDTH, 64, AXI and APB data width (no width conversion); STRB width = C_AXI_DATA_WIDTH/8

Ports:
AXI_ACLK  in  1  clock
AXI_ARESET_N  in  1  reset; asynchronous assert, active-low
AXI_AWID  in  C_AXI_ID_WIDTH  write ID, captured on AW handshake
AXI_AWADDR  in  C_AXI_ADDR_WIDTH  start address
AXI_AWLEN  in  4  beats-1 (1..16 beats)
AXI_AWSIZE  in  3  bytes/beat = 1<<AWSIZE; must be <= log2(C_AXI_DATA_WIDTH/8)
AXI_AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 treated as INCR
AXI_AWVALID  in  1  AW valid
AXI_AWREADY  out  1  AW ready
AXI_WDATA  in  C_AXI_DATA_WIDTH  write data
AXI_WSTRB  in  C_AXI_DATA_WIDTH/8  byte strobes
AXI_WLAST  in  1  last beat (ignored; the AWLEN count is authoritative)
AXI_WVALID  in  1  W valid
AXI_WREADY  out  1  W ready
AXI_BID  out  C_AXI_ID_WIDTH  captured AWID
AXI_BRESP  out  2  00 OKAY, 10 SLVERR
AXI_BVALID  out  1  B valid
AXI_BREADY  in  1  B ready
APB_PADDR  out  C_AXI_ADDR_WIDTH  beat address
APB_PSEL  out  1  select
APB_PENABLE  out  1  access phase
APB_PWDATA  out  C_AXI_DATA_WIDTH  registered beat data
APB_PSTRB  out  C_AXI_DATA_WIDTH/8  registered beat strobes
APB_PREADY  in  1  completer ready
APB_PSLVERR  in  1  completer error, sampled with PREADY

Behaviour:
- Reset (async, AXI_ARESET_N=0): state IDLE. AWREADY, WREADY, BVALID, PSEL and PENABLE are 0. PADDR, PWDATA, PSTRB, BID and BRESP are 0. The beat counter and error flag are cleared. Reset mid-burst abandons the burst with no B response.
- All outputs are registered.
- FSM states: IDLE, WDATA, SETUP, ACCESS, BRESP.
- IDLE: AWREADY=1. On AWVALID&&AWREADY:
  - capture ID, ADDR, LEN, SIZE, BURST;
  - set beat count = 0 and error flag = 0;
  - go to WDATA.
- WDATA: WREADY=1. On WVALID&&WREADY:
  - latch WDATA/WSTRB into PWDATA/PSTRB;
  - drive PADDR = current beat address;
  - set PSEL=1 and go to SETUP.
  - AW and W handshakes never complete in the same cycle.
- SETUP: exactly one cycle. Next cycle PENABLE=1 and state goes to ACCESS.
- ACCESS: hold all APB outputs until PREADY=1. On PREADY:
  - error flag |= PSLVERR;
  - PSEL=0 and PENABLE=0 the next cycle;
  - if beat count == LEN, go to BRESP; otherwise increment the count, advance the address and return to WDATA.
- BRESP: BVALID=1, BID=captured ID, BRESP = error flag ? 2'b10 : 2'b00. Hold until BREADY. The cycle after the handshake: BVALID=0 and state IDLE (AWREADY=1).
- Minimum latency per beat, PREADY tied high: W handshake in cycle n gives SETUP in n+1, ACCESS in n+2, WREADY=1 again in n+3.
- Address update uses unsigned arithmetic at C_AXI_ADDR_WIDTH:
  - FIXED: address unchanged.
  - INCR: address += 1<<SIZE, wrapping modulo 2^C_AXI_ADDR_WIDTH.
  - WRAP: container = (LEN+1)<<SIZE, lower = address aligned down to the container. Next = address + (1<<SIZE); if next == lower + container, next = lower.
- A PSLVERR on one beat does not abort the burst; all LEN+1 APB transfers are still issued.
- PSTRB is passed through unmodified; no lane steering.

Test Plan:
- Single beat: AWADDR=0x100, LEN=0, SIZE=3, INCR, WDATA=0xA5A5, PREADY=1 -> one APB write at 0x100 with PWDATA=0xA5A5; PSEL 2 cycles, PENABLE 1 cycle; BRESP=00, BID=AWID.
- INCR 4 beats: AWADDR=0x1000, SIZE=2 -> PADDR sequence 0x1000, 0x1004, 0x1008, 0x100C; exactly one B response.
- WRAP 4 beats: AWADDR=0x38, SIZE=3 -> PADDR sequence 0x38, 0x20, 0x28, 0x30.
- FIXED 3 beats with PREADY wait states of 0, 3 and 1 cycles -> PADDR constant; APB signals stable during each wait; each next WREADY waits for the previous PREADY.
- PSLVERR on beat 2 of 4 -> all 4 APB transfers issued; BRESP=10.
- Two further cases:
  - BREADY low for 5 cycles: BVALID and BID held; AWREADY stays 0 until the B handshake.
  - Reset asserted while in ACCESS: PSEL, PENABLE and BVALID drop immediately; AWREADY=1 after reset release.

Source files
------------

// File: rtl/gon_axi2apb_wr_bridge.sv
// Write half of the AXI-to-APB bridge: one AXI write burst at a time, one APB write per beat,
// and a single B response per burst carrying the OR of all PSLVERRs.
module gon_axi2apb_wr_bridge #(
    parameter int C_AXI_ID_WIDTH   = 1,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 64
) (
    input  logic                          AXI_ACLK,
    input  logic                          AXI_ARESET_N,
    input  logic [C_AXI_ID_WIDTH-1:0]     AXI_AWID,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   AXI_AWADDR,
    input  logic [3:0]                    AXI_AWLEN,
    input  logic [2:0]                    AXI_AWSIZE,
    input  logic [1:0]                    AXI_AWBURST,
    input  logic                          AXI_AWVALID,
    output logic                          AXI_AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] AXI_WSTRB,
    input  logic                          AXI_WLAST,
    input  logic                          AXI_WVALID,
    output logic                          AXI_WREADY,
    output logic [C_AXI_ID_WIDTH-1:0]     AXI_BID,
    output logic [1:0]                    AXI_BRESP,
    output logic                          AXI_BVALID,
    input  logic                          AXI_BREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0]   APB_PADDR,
    output logic                          APB_PSEL,
    output logic                          APB_PENABLE,
    output logic [C_AXI_DATA_WIDTH-1:0]   APB_PWDATA,
    output logic [C_AXI_DATA_WIDTH/8-1:0] APB_PSTRB,
    input  logic                          APB_PREADY,
    input  logic                          APB_PSLVERR
);
    localparam int IDW = C_AXI_ID_WIDTH;
    localparam int AW  = C_AXI_ADDR_WIDTH;
    localparam int DW  = C_AXI_DATA_WIDTH;
    localparam int SW  = C_AXI_DATA_WIDTH / 8;
    localparam logic [AW-1:0] ONE = 1;

    typedef enum logic [2:0] {S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_BRESP} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [3:0]      len_q, len_d;
    logic [2:0]      size_q, size_d;
    logic [1:0]      burst_q, burst_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            err_q, err_d;

    logic            awready_q, awready_d;
    logic            wready_q, wready_d;
    logic            bvalid_q, bvalid_d;
    logic            psel_q, psel_d;
    logic            penable_q, penable_d;
    logic [AW-1:0]   paddr_q, paddr_d;
    logic [DW-1:0]   pwdata_q, pwdata_d;
    logic [SW-1:0]   pstrb_q, pstrb_d;
    logic [IDW-1:0]  bid_q, bid_d;
    logic [1:0]      bresp_q, bresp_d;

    logic [AW-1:0]   step, container, lower, incr_addr, wrap_addr, next_addr;

    // WLAST is deliberately ignored; the captured AWLEN decides the last beat.
    logic unused_wlast;
    assign unused_wlast = AXI_WLAST;

    // Beat address advance; a WRAP burst folds back to the container base at its upper edge.
    always_comb begin
        step      = ONE << size_q;
        container = (AW'(len_q) + ONE) << size_q;
        lower     = addr_q & ~(container - ONE);
        incr_addr = addr_q + step;
        wrap_addr = (incr_addr == lower + container) ? lower : incr_addr;
        case (burst_q)
            2'b00:   next_addr = addr_q;
            2'b10:   next_addr = wrap_addr;
            default: next_addr = incr_addr;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        size_d   = size_q;
        burst_d  = burst_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        bid_d    = bid_q;
        bresp_d  = bresp_q;

        case (state_q)
            S_IDLE: begin
                if (AXI_AWVALID && awready_q) begin
                    id_d    = AXI_AWID;
                    addr_d  = AXI_AWADDR;
                    len_d   = AXI_AWLEN;
                    size_d  = AXI_AWSIZE;
                    burst_d = AXI_AWBURST;
                    cnt_d   = 4'd0;
                    err_d   = 1'b0;
                    state_d = S_WDATA;
                end
            end
            S_WDATA: begin
                if (AXI_WVALID && wready_q) begin
                    pwdata_d = AXI_WDATA;
                    pstrb_d  = AXI_WSTRB;
                    paddr_d  = addr_q;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (APB_PREADY) begin
                    err_d = err_q | APB_PSLVERR;
                    if (cnt_q == len_q) begin
                        bid_d   = id_q;
                        bresp_d = (err_q | APB_PSLVERR) ? 2'b10 : 2'b00;
                        state_d = S_BRESP;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        addr_d  = next_addr;
                        state_d = S_WDATA;
                    end
                end
            end
            S_BRESP: begin
                if (AXI_BREADY && bvalid_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake and APB control outputs are registered decodes of the next state.
        awready_d = (state_d == S_IDLE);
        wready_d  = (state_d == S_WDATA);
        psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
        penable_d = (state_d == S_ACCESS);
        bvalid_d  = (state_d == S_BRESP);
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESET_N) begin
        if (!AXI_ARESET_N) begin
            state_q   <= S_IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            bid_q     <= '0;
            bresp_q   <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
        end
    end

    assign AXI_AWREADY = awready_q;
    assign AXI_WREADY  = wready_q;
    assign AXI_BVALID  = bvalid_q;
    assign AXI_BID     = bid_q;
    assign AXI_BRESP   = bresp_q;
    assign APB_PSEL    = psel_q;
    assign APB_PENABLE = penable_q;
    assign APB_PADDR   = paddr_q;
    assign APB_PWDATA  = pwdata_q;
    assign APB_PSTRB   = pstrb_q;

endmodule

// File: tb/tb_gon_axi2apb_wr_bridge.sv
// Bench for gon_axi2apb_wr_bridge: directed vector table, reset-in-ACCESS sequence and random
// bursts checked against an arithmetic address/response model.
module tb_gon_axi2apb_wr_bridge;
    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int SW  = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [IDW-1:0] awid;
    logic [AW-1:0]  awaddr;
    logic [3:0]     awlen;
    logic [2:0]     awsize;
    logic [1:0]     awburst;
    logic           awvalid, awready;
    logic [DW-1:0]  wdata;
    logic [SW-1:0]  wstrb;
    logic           wlast, wvalid, wready;
    logic [IDW-1:0] bid;
    logic [1:0]     bresp;
    logic           bvalid, bready;
    logic [AW-1:0]  paddr;
    logic           psel, penable;
    logic [DW-1:0]  pwdata;
    logic [SW-1:0]  pstrb;
    logic           pready, pslverr;

    always #5 clk = ~clk;

    gon_axi2apb_wr_bridge #(
        .C_AXI_ID_WIDTH  (IDW),
        .C_AXI_ADDR_WIDTH(AW),
        .C_AXI_DATA_WIDTH(DW)
    ) dut (
        .AXI_ACLK    (clk),
        .AXI_ARESET_N(rst_n),
        .AXI_AWID    (awid),
        .AXI_AWADDR  (awaddr),
        .AXI_AWLEN   (awlen),
        .AXI_AWSIZE  (awsize),
        .AXI_AWBURST (awburst),
        .AXI_AWVALID (awvalid),
        .AXI_AWREADY (awready),
        .AXI_WDATA   (wdata),
        .AXI_WSTRB   (wstrb),
        .AXI_WLAST   (wlast),
        .AXI_WVALID  (wvalid),
        .AXI_WREADY  (wready),
        .AXI_BID     (bid),
        .AXI_BRESP   (bresp),
        .AXI_BVALID  (bvalid),
        .AXI_BREADY  (bready),
        .APB_PADDR   (paddr),
        .APB_PSEL    (psel),
        .APB_PENABLE (penable),
        .APB_PWDATA  (pwdata),
        .APB_PSTRB   (pstrb),
        .APB_PREADY  (pready),
        .APB_PSLVERR (pslverr)
    );

    int total = 0;
    int bad   = 0;
    int apb_cnt = 0;
    int b_cnt   = 0;

    // Independent transfer counters, sampled after the inputs for the next edge have settled.
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (psel && penable && pready) apb_cnt++;
            if (bvalid && bready) b_cnt++;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference address of beat i, derived directly from the burst rules.
    function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [3:0] len,
                                               input logic [2:0] size, input logic [1:0] burst,
                                               input int i);
        longint unsigned bytes, cont, lo, av;
        av    = longint'(a);
        bytes = 64'd1 << size;
        cont  = (longint'(len) + 64'd1) * bytes;
        case (burst)
            2'b00:   return a;
            2'b10: begin
                lo = av - (av % cont);
                return 32'(lo + ((av - lo) + longint'(i) * bytes) % cont);
            end
            default: return 32'((av + longint'(i) * bytes) % (64'd1 << 32));
        endcase
    endfunction

    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input logic [15:0] errmask, input logic [15:0][3:0] waits,
                             input logic [15:0][31:0] exp_addr, input int bdly,
                             input logic [1:0] exp_bresp);
        bit ok;
        int apb0, b0;
        logic [63:0] d;
        logic [7:0] s;
        apb0 = apb_cnt;
        b0   = b_cnt;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        ok = 0;
        for (int k = 0; k < 16; k++) begin
            if (awready) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("aw_handshake", ok, 1);
        if (!ok) begin awvalid = 1'b0; return; end
        @(negedge clk);
        awvalid = 1'b0;
        chk("awready_after_aw", awready, 0);
        for (int i = 0; i <= int'(len); i++) begin
            d = {$urandom, $urandom};
            s = 8'($urandom);
            wdata = d; wstrb = s; wlast = (i == int'(len)); wvalid = 1'b1;
            ok = 0;
            for (int k = 0; k < 16; k++) begin
                if (wready) begin ok = 1; break; end
                @(negedge clk);
            end
            chk("w_handshake", ok, 1);
            if (!ok) begin wvalid = 1'b0; return; end
            @(negedge clk);
            wvalid = 1'b0;
            chk("setup_ctrl", {psel, penable, wready}, 3'b100);
            chk("setup_paddr", paddr, exp_addr[i]);
            chk("setup_pwdata", pwdata, d);
            chk("setup_pstrb", pstrb, s);
            @(negedge clk);
            chk("access_ctrl", {psel, penable}, 2'b11);
            for (int w = 0; w < int'(waits[i]); w++) begin
                @(negedge clk);
                chk("wait_hold", {paddr, pstrb, psel, penable, wready}, {exp_addr[i], s, 3'b110});
                chk("wait_pwdata", pwdata, d);
            end
            pready = 1'b1;
            pslverr = errmask[i];
            @(negedge clk);
            pready = 1'b0;
            pslverr = 1'b0;
            chk("post_access_ctrl", {psel, penable}, 2'b00);
            if (i < int'(len)) chk("next_wready", wready, 1);
        end
        chk("bvalid", bvalid, 1);
        chk("bid", bid, id);
        chk("bresp", bresp, exp_bresp);
        chk("awready_in_b", awready, 0);
        for (int k = 0; k < bdly; k++) begin
            @(negedge clk);
            chk("b_hold", {bvalid, bid, bresp, awready}, {1'b1, id, exp_bresp, 1'b0});
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("after_b", {bvalid, awready}, 2'b01);
        chk("apb_count", apb_cnt - apb0, int'(len) + 1);
        chk("b_count", b_cnt - b0, 1);
    endtask

    typedef struct {
        logic [3:0]   id;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [2:0]   size;
        logic [1:0]   burst;
        logic [15:0]  errmask;
        logic [15:0]  waits;
        int           bdly;
        logic [127:0] exp_addr;
        logic [1:0]   exp_bresp;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                                input logic [2:0] size, input logic [1:0] burst,
                                input logic [15:0] em, input logic [15:0] waits, input int bdly,
                                input logic [127:0] ea, input logic [1:0] br);
        vec_t v;
        v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
        v.errmask = em; v.waits = waits; v.bdly = bdly; v.exp_addr = ea; v.exp_bresp = br;
        return v;
    endfunction

    vec_t vecs[7];

    initial begin
        logic [15:0][3:0]  wt;
        logic [15:0][31:0] ea;
        logic [15:0]       em;
        logic [31:0]       ra;
        logic [3:0]        rl;
        logic [2:0]        rs;
        logic [1:0]        rb;
        logic              anyerr;
        int                b0;

        rst_n = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        bready = 1'b0; pready = 1'b0; pslverr = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_ctrl", {awready, wready, bvalid, psel, penable}, 5'b0);
        chk("reset_regs", {paddr, pstrb, bid, bresp}, 46'h0);
        chk("reset_pwdata", pwdata, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("awready_after_reset", awready, 1);

        vecs[0] = mk(4'h3, 32'h100, 4'd0, 3'd3, 2'b01, 16'h0, 16'h0000, 0,
                     {32'h0, 32'h0, 32'h0, 32'h100}, 2'b00);
        vecs[1] = mk(4'h5, 32'h1000, 4'd3, 3'd2, 2'b01, 16'h0, 16'h0000, 5,
                     {32'h100C, 32'h1008, 32'h1004, 32'h1000}, 2'b00);
        vecs[2] = mk(4'h9, 32'h38, 4'd3, 3'd3, 2'b10, 16'h0, 16'h0000, 0,
                     {32'h30, 32'h28, 32'h20, 32'h38}, 2'b00);
        vecs[3] = mk(4'h1, 32'h200, 4'd2, 3'd2, 2'b00, 16'h0, 16'h0130, 1,
                     {32'h0, 32'h200, 32'h200, 32'h200}, 2'b00);
        vecs[4] = mk(4'hA, 32'h3000, 4'd3, 3'd3, 2'b01, 16'h0002, 16'h0000, 0,
                     {32'h3018, 32'h3010, 32'h3008, 32'h3000}, 2'b10);
        vecs[5] = mk(4'hF, 32'hFFFF_FFF8, 4'd1, 3'd3, 2'b11, 16'h0, 16'h0000, 0,
                     {32'h0, 32'h0, 32'h0, 32'hFFFF_FFF8}, 2'b00);
        vecs[6] = mk(4'h6, 32'h44, 4'd1, 3'd2, 2'b10, 16'h0001, 16'h0000, 2,
                     {32'h0, 32'h0, 32'h40, 32'h44}, 2'b10);

        for (int v = 0; v < 7; v++) begin
            wt = '0;
            ea = '0;
            for (int i = 0; i < 4; i++) begin
                wt[i] = vecs[v].waits[4*i +: 4];
                ea[i] = vecs[v].exp_addr[32*i +: 32];
            end
            run_burst(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst,
                      vecs[v].errmask, wt, ea, vecs[v].bdly, vecs[v].exp_bresp);
        end

        // Reset while a transfer sits in ACCESS with PREADY low.
        b0 = b_cnt;
        awid = 4'h7; awaddr = 32'h500; awlen = 4'd1; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        chk("rst_seq_awready", awready, 1);
        @(negedge clk);
        awvalid = 1'b0;
        wdata = 64'h1234_5678_9ABC_DEF0; wstrb = 8'hFF; wvalid = 1'b1;
        chk("rst_seq_wready", wready, 1);
        @(negedge clk);
        wvalid = 1'b0;
        @(negedge clk);
        chk("rst_seq_access", {psel, penable}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", {psel, penable, bvalid, awready, wready}, 5'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_release", {awready, psel, penable, bvalid}, 4'b1000);
        chk("rst_mid_no_b", b_cnt - b0, 0);

        for (int n = 0; n < 40; n++) begin
            rb = 2'($urandom_range(0, 3));
            rs = 3'($urandom_range(0, 3));
            if (rb == 2'b10) rl = 4'((2 << $urandom_range(0, 3)) - 1);
            else             rl = 4'($urandom_range(0, 15));
            ra = $urandom;
            if (rb == 2'b10) ra = ra & ~((32'd1 << rs) - 32'd1);
            em = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0;
            wt = '0;
            ea = '0;
            anyerr = 1'b0;
            for (int i = 0; i <= int'(rl); i++) begin
                wt[i] = 4'($urandom_range(0, 2));
                ea[i] = model_addr(ra, rl, rs, rb, i);
                anyerr = anyerr | em[i];
            end
            run_burst(4'($urandom), ra, rl, rs, rb, em, wt, ea, $urandom_range(0, 3),
                      anyerr ? 2'b10 : 2'b00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
